uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter with a small input FIFO, the transmit-side counterpart of the existing oversampling receiver. It shares the 16x baud tick from the existing baud-rate generator: 9600 baud at 50 MHz, one tick every 326 clocks. It accepts bytes from the core, e.g. ALU results, over a write strobe, buffers them, and serialises each as an 8N1 frame, LSB first. Optional parity is supported. It sits beside the receiver in the UART top level.

## Interface
- DBIT, 8: data bits per frame.
- SB_TICK, 16: stop-bit length in ticks; 16 = 1 stop bit, 32 = 2 stop bits.
- PARITY, 0: 0 = none, 1 = even, 2 = odd.
- FIFO_AW, 2: FIFO address width; depth is 2^FIFO_AW, 4 entries by default.
- i_clk  in  1  system clock. One clock; reset is synchronous and active-high.
- i_reset  in  1  synchronous, active-high reset.
- i_tick  in  1  16x oversampling tick, one clock wide, from the baud-rate generator.
- i_wr  in  1  write strobe; pushes i_wr_data into the FIFO.
- i_wr_data  in  DBIT  byte to transmit.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_busy  out  1  FSM not in IDLE.
- o_tx_done  out  1  one-clock pulse at the end of each frame's stop bit.
- o_tx  out  1  serial line, registered, idle high.

## Operation
- FIFO
  - Circular buffer with read/write pointers of FIFO_AW+1 bits; the MSB distinguishes full from empty.
  - A write while o_full is ignored, even if a pop occurs in the same cycle. Data and pointers do not change.
  - A write and a pop in the same cycle, not full and not empty: both happen, and occupancy is unchanged.
- FSM states: IDLE, START, DATA, PARITY_S, STOP.
  - IDLE: o_tx = 1. If !o_empty: pop the head into shift register b, clear tick counter s, go to START.
  - START: o_tx = 0. On each i_tick, s++. When s = 15 on a tick: s = 0, bit counter n = 0, go to DATA.
  - DATA: o_tx = b[0]. On the tick where s = 15: shift b right, s = 0. If n = DBIT-1, go to PARITY_S (PARITY != 0) or STOP; otherwise n++.
  - PARITY_S: o_tx = XOR of the frame's data bits (even), or its inverse (odd). Duration 16 ticks, then go to STOP.
  - STOP: o_tx = 1. On the tick where s = SB_TICK-1: pulse o_tx_done and go to IDLE.
- Parity is computed at load time and held in a register. It is not recomputed from the shifting b.
- No i_tick means no progress: the FSM holds its state and o_tx indefinitely.
- Back-to-back frames: IDLE lasts exactly one clock between the STOP exit and the next START. There are no extra idle ticks.

## Timing
- Reset values:
  - o_tx = 1, o_busy = 0, o_tx_done = 0, o_empty = 1, o_full = 0.
  - FSM = IDLE; s, n, b and the pointers = 0.
- Reset mid-frame: the frame is abandoned and the FIFO is flushed. o_tx = 1 from the first clock after the reset edge.
- Write latency: i_wr at edge N with the FSM idle and the FIFO empty.
  - Edge N: the byte is stored and o_empty falls.
  - Edge N+1: pop; o_tx falls, o_busy rises, and o_empty rises again.
- The start bit is 15 to 16 ticks long, because the START entry is not tick-aligned. Every later bit is exactly 16 ticks (5216 clocks at default rates).
- o_tx_done is high for the single clock after the final STOP tick edge. o_busy is 0 in that same cycle when the FIFO is empty.
- o_full and o_empty are combinational from the pointers and valid the cycle after any push or pop.

## Structure
- Package uart_pkg holds:
  - state encodings IDLE/START/DATA/PARITY_S/STOP;
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD;
  - the 16x oversample constant, shared with the receiver.
- Sub-module uart_fifo, parameterised by DBIT and FIFO_AW and reusable on the RX side. uart_tx instantiates it and holds the FSM, counters, shift register and parity bit.

## Test plan
- Single frame: i_tick every 326 clocks; write 0x55.
  - o_tx reads 0, 1,0,1,0,1,0,1,0, 1 with LSB first.
  - Each data bit lasts 5216 clocks, and o_tx_done pulses once.
- Back-to-back: write 0x0A, then 0x20 one clock later.
  - Two contiguous frames with exactly one IDLE clock between them.
  - Data bits 0,1,0,1,0,0,0,0 then 0,0,0,0,0,1,0,0; two o_tx_done pulses.
- Overflow: six writes on consecutive clocks, from an idle, empty block.
  - The first byte pops immediately, so o_full rises after the 5th write.
  - The 6th byte is dropped; exactly 5 frames go out, in order.
- Parity: PARITY=1, write 0x07 → parity bit 1. PARITY=2, write 0x07 → parity bit 0. The stop bit follows the parity bit in both cases.
- Reset mid-frame: assert i_reset during data bit 3 of a frame with 2 more bytes queued.
  - o_tx = 1, o_empty = 1 and o_busy = 0 one clock after the reset edge.
  - No further frames are sent.
- Tick stall: hold i_tick low for 10000 clocks mid-DATA. o_tx and the state stay frozen, and the frame resumes correctly when ticks return.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and the
// 16x oversampling factor used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY_S,
    STOP
  } tx_state_e;

  localparam int unsigned PAR_NONE   = 0;
  localparam int unsigned PAR_EVEN   = 1;
  localparam int unsigned PAR_ODD    = 2;

  localparam int unsigned OVERSAMPLE = 16;

endpackage

// File: rtl/uart_fifo.sv
// Small circular FIFO for UART byte buffering. Pointers carry one extra MSB
// so that full and empty can be told apart when the address bits match.
module uart_fifo #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [DBIT-1:0] i_wr_data,
  input  logic            i_rd,
  output logic [DBIT-1:0] o_rd_data,
  output logic            o_full,
  output logic            o_empty
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  logic [DBIT-1:0]  mem_q [DEPTH];
  logic [DBIT-1:0]  mem_d [DEPTH];
  logic [FIFO_AW:0] wp_q, wp_d;
  logic [FIFO_AW:0] rp_q, rp_d;
  logic             do_wr;
  logic             do_rd;

  assign o_full    = (wp_q[FIFO_AW] != rp_q[FIFO_AW]) &&
                     (wp_q[FIFO_AW-1:0] == rp_q[FIFO_AW-1:0]);
  assign o_empty   = (wp_q == rp_q);
  assign o_rd_data = mem_q[rp_q[FIFO_AW-1:0]];

  // Push/pop qualification and next pointer/storage values; a write while
  // full is dropped even when a pop happens in the same cycle.
  always_comb begin
    do_wr = i_wr && !o_full;
    do_rd = i_rd && !o_empty;
    mem_d = mem_q;
    wp_d  = wp_q;
    rp_d  = rp_q;
    if (do_wr) begin
      mem_d[wp_q[FIFO_AW-1:0]] = i_wr_data;
      wp_d = wp_q + 1'b1;
    end
    if (do_rd) begin
      rp_d = rp_q + 1'b1;
    end
  end

  // Pointer and storage registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wp_q <= '0;
      rp_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffers bytes in a small FIFO and serialises each one as
// start, DBIT data bits LSB first, optional parity, and stop, paced by the
// 16x oversampling tick from the shared baud-rate generator.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16,
  parameter int unsigned PARITY  = 0,
  parameter int unsigned FIFO_AW = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_tick,
  input  logic            i_wr,
  input  logic [DBIT-1:0] i_wr_data,
  output logic            o_full,
  output logic            o_empty,
  output logic            o_busy,
  output logic            o_tx_done,
  output logic            o_tx
);

  localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  tx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            pop;
  logic [DBIT-1:0] fifo_data;
  logic            fifo_empty;

  uart_fifo #(
    .DBIT    (DBIT),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_wr      (i_wr),
    .i_wr_data (i_wr_data),
    .i_rd      (pop),
    .o_rd_data (fifo_data),
    .o_full    (o_full),
    .o_empty   (fifo_empty)
  );

  assign o_empty   = fifo_empty;
  assign o_busy    = (state_q != IDLE);
  assign o_tx_done = done_q;
  assign o_tx      = tx_q;

  // Frame sequencing: next state, tick/bit counters, shift register, parity.
  // The line value is derived from the next state so o_tx can be a flop
  // without lagging the state by a cycle.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    par_d   = par_q;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          b_d     = fifo_data;
          par_d   = (^fifo_data) ^ (PARITY == PAR_ODD);
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (i_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            n_d     = '0;
            state_d = DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d = '0;
            b_d = b_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
              state_d = (PARITY != PAR_NONE) ? PARITY_S : STOP;
            end else begin
              n_d = n_q + 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      PARITY_S: begin
        if (i_tick) begin
          if (s_q == SW'(OVERSAMPLE - 1)) begin
            s_d     = '0;
            state_d = STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            s_d     = '0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    case (state_d)
      START:    tx_d = 1'b0;
      DATA:     tx_d = b_d[0];
      PARITY_S: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (no parity, even, odd) share clock,
// reset, tick and write data. A frame-level reference model per instance
// predicts every output each cycle; table vectors and directed sequences
// add explicit checks of serial frames and corner cases.
module tb_uart_tx;

  localparam int unsigned DIV      = 4;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned SBT      = 16;
  localparam int unsigned BIT_CLKS = 16 * DIV;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       stall;
  logic [2:0] wr_w;
  logic [7:0] wdata;
  logic [2:0] full_w, empty_w, busy_w, done_w, tx_w;

  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx #(
      .DBIT    (8),
      .SB_TICK (SBT),
      .PARITY  (g),
      .FIFO_AW (2)
    ) u_dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_tick    (tick),
      .i_wr      (wr_w[g]),
      .i_wr_data (wdata),
      .o_full    (full_w[g]),
      .o_empty   (empty_w[g]),
      .o_busy    (busy_w[g]),
      .o_tx_done (done_w[g]),
      .o_tx      (tx_w[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Tick generator: one-clock pulse every DIV clocks unless stalled.
  initial begin
    int cnt;
    cnt  = 0;
    tick = 1'b0;
    forever begin
      @(negedge clk);
      cnt = (cnt == DIV - 1) ? 0 : cnt + 1;
      tick = (!stall && cnt == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line level for tick t of a frame: start, 8 data bits LSB first,
  // optional parity, then stop.
  function automatic logic frame_bit(input int par, input int t, input logic [7:0] b);
    int idx;
    idx = t / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
    if (idx == 9 && par != 0) return (^b) ^ (par == 2);
    return 1'b1;
  endfunction

  // Reference model: a byte queue plus "frame in flight for N ticks".
  for (genvar g = 0; g < 3; g++) begin : g_ref
    logic [7:0] q [$];
    logic [7:0] cur;
    bit         act;
    bit         done_m;
    bit         full_pre;
    int         t;
    int         frame_ticks;
    initial begin
      act = 0; t = 0; done_m = 0; cur = '0;
      frame_ticks = 16 * (9 + (g != 0 ? 1 : 0)) + SBT;
      forever begin
        @(posedge clk);
        #1;
        if (rst) begin
          q.delete();
          act = 0; t = 0; done_m = 0;
        end else begin
          full_pre = (q.size() == DEPTH);
          done_m   = 0;
          if (act) begin
            if (tick) begin
              t++;
              if (t == frame_ticks) begin
                act = 0;
                done_m = 1;
              end
            end
          end else if (q.size() != 0) begin
            cur = q.pop_front();
            act = 1;
            t   = 0;
          end
          if (wr_w[g] && !full_pre) q.push_back(wdata);
        end
        chk($sformatf("ref%0d_tx", g),    32'(tx_w[g]),    32'(act ? frame_bit(g, t, cur) : 1'b1));
        chk($sformatf("ref%0d_busy", g),  32'(busy_w[g]),  32'(act));
        chk($sformatf("ref%0d_done", g),  32'(done_w[g]),  32'(done_m));
        chk($sformatf("ref%0d_empty", g), 32'(empty_w[g]), 32'(q.size() == 0));
        chk($sformatf("ref%0d_full", g),  32'(full_w[g]),  32'(q.size() == DEPTH));
      end
    end
  end

  task automatic wr(input int d, input logic [7:0] data);
    @(negedge clk);
    wdata   = data;
    wr_w[d] = 1'b1;
    @(negedge clk);
    wr_w = '0;
  endtask

  task automatic wait_done(input int d, input int budget, input string name);
    int c;
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (!done_w[d] && c < budget);
    chk(name, 32'(done_w[d]), 32'd1);
  endtask

  task automatic wait_ticks(input int n, input string name);
    int c, k;
    c = 0; k = 0;
    while (k < n && c < n * DIV + 100) begin
      @(posedge clk); #1; c++;
      if (tick) k++;
    end
    chk(name, k, n);
  endtask

  // Samples the line mid-bit by counting ticks from the pop edge.
  task automatic capture(input int d, input int nbits, input bit chk_period,
                         output logic [10:0] bits, output int ndone);
    int t, cyc, last, nchg, budget;
    logic prev;
    t = 0; cyc = 0; last = 0; nchg = 0; ndone = 0;
    budget = nbits * BIT_CLKS + 100;
    bits = '1;
    @(posedge clk); #1;
    prev = tx_w[d];
    while (t < nbits * 16 && cyc < budget) begin
      @(posedge clk); #1; cyc++;
      if (done_w[d]) ndone++;
      if (tick) begin
        t++;
        if (t % 16 == 8) bits[t/16] = tx_w[d];
      end
      if (tx_w[d] !== prev) begin
        if (chk_period && nchg > 0) chk("bit_period", cyc - last, BIT_CLKS);
        last = cyc; nchg++; prev = tx_w[d];
      end
    end
    chk("capture_ticks", t, nbits * 16);
    repeat (4) begin
      @(posedge clk); #1;
      if (done_w[d]) ndone++;
    end
  endtask

  typedef struct {
    int         dut;
    logic [7:0] data;
    int         nbits;
    logic [10:0] frame;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [10:0] bits;
    int          nd, extra, d, c;
    rst = 1'b1; wr_w = '0; wdata = '0; stall = 1'b0;

    vecs[0] = '{0, 8'h55, 10, {1'b1, 1'b1, 8'h55, 1'b0}};
    vecs[1] = '{0, 8'h00, 10, {1'b1, 1'b1, 8'h00, 1'b0}};
    vecs[2] = '{0, 8'hFF, 10, {1'b1, 1'b1, 8'hFF, 1'b0}};
    vecs[3] = '{1, 8'h07, 11, {1'b1, 1'b1, 8'h07, 1'b0}};
    vecs[4] = '{2, 8'h07, 11, {1'b1, 1'b0, 8'h07, 1'b0}};
    vecs[5] = '{1, 8'hA5, 11, {1'b1, 1'b0, 8'hA5, 1'b0}};
    vecs[6] = '{2, 8'h80, 11, {1'b1, 1'b0, 8'h80, 1'b0}};
    vecs[7] = '{1, 8'h80, 11, {1'b1, 1'b1, 8'h80, 1'b0}};

    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_tx",    32'(tx_w[i]),    32'd1);
      chk("reset_busy",  32'(busy_w[i]),  32'd0);
      chk("reset_done",  32'(done_w[i]),  32'd0);
      chk("reset_empty", 32'(empty_w[i]), 32'd1);
      chk("reset_full",  32'(full_w[i]),  32'd0);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Table-driven single frames.
    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].dut, vecs[i].data);
      chk($sformatf("vec%0d_write_latency", i), 32'(empty_w[vecs[i].dut]), 32'd0);
      capture(vecs[i].dut, vecs[i].nbits, (i == 0), bits, nd);
      chk($sformatf("vec%0d_frame", i), 32'(bits), 32'(vecs[i].frame));
      chk($sformatf("vec%0d_done_count", i), nd, 1);
    end

    // Back-to-back frames with a single idle clock between them.
    @(negedge clk); wdata = 8'h0A; wr_w[0] = 1'b1;
    @(negedge clk); wdata = 8'h20;
    @(negedge clk); wr_w = '0;
    wait_done(0, 200 * DIV, "b2b_done1");
    chk("b2b_idle_busy", 32'(busy_w[0]), 32'd0);
    @(posedge clk); #1;
    chk("b2b_restart_busy", 32'(busy_w[0]), 32'd1);
    chk("b2b_restart_tx",   32'(tx_w[0]),   32'd0);
    wait_done(0, 200 * DIV, "b2b_done2");
    chk("b2b_after_empty", 32'(empty_w[0]), 32'd1);

    // Overflow: six consecutive writes, the sixth is dropped.
    @(negedge clk); wr_w[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wdata = 8'h31 + 8'(i);
      @(negedge clk);
      if (i == 4) chk("ovf_full_after5", 32'(full_w[0]), 32'd1);
    end
    wr_w = '0;
    chk("ovf_full_after6", 32'(full_w[0]), 32'd1);
    for (int i = 0; i < 5; i++) wait_done(0, 200 * DIV, "ovf_done");
    extra = 0;
    repeat (400 * DIV) begin
      @(posedge clk); #1;
      if (done_w[0] || busy_w[0]) extra++;
    end
    chk("ovf_no_sixth", extra, 0);
    chk("ovf_empty", 32'(empty_w[0]), 32'd1);

    // Reset during data bit 3 with two bytes queued.
    @(negedge clk); wr_w[0] = 1'b1; wdata = 8'h11;
    @(negedge clk); wdata = 8'h22;
    @(negedge clk); wdata = 8'h33;
    @(negedge clk); wr_w = '0;
    wait_ticks(4 * 16 + 6, "rst_reach_bit3");
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("rst_mid_tx",    32'(tx_w[0]),    32'd1);
    chk("rst_mid_empty", 32'(empty_w[0]), 32'd1);
    chk("rst_mid_busy",  32'(busy_w[0]),  32'd0);
    extra = 0;
    repeat (400 * DIV) begin
      @(posedge clk); #1;
      if (busy_w[0] || !tx_w[0] || done_w[0]) extra++;
    end
    chk("rst_no_more_frames", extra, 0);

    // Tick stall mid-DATA.
    wr(0, 8'hC3);
    wait_ticks(3 * 16 + 4, "stall_reach_data");
    @(negedge clk); stall = 1'b1;
    bits[0] = tx_w[0];
    extra = 0;
    repeat (10000) begin
      @(posedge clk); #1;
      if (tx_w[0] !== bits[0] || busy_w[0] !== 1'b1 || done_w[0]) extra++;
    end
    chk("stall_frozen", extra, 0);
    @(negedge clk); stall = 1'b0;
    wait_done(0, 200 * DIV, "stall_resume_done");

    // Randomised writes to random subsets of instances.
    repeat (60) begin
      d = $urandom_range(1, 7);
      @(negedge clk);
      wdata = 8'($urandom);
      wr_w  = 3'(d);
      @(negedge clk);
      wr_w = '0;
      repeat ($urandom_range(0, 80)) @(negedge clk);
    end
    c = 0;
    do begin
      @(posedge clk); #1; c++;
    end while (!(empty_w == 3'b111 && busy_w == 3'b000) && c < 30000);
    chk("random_drain", 32'({empty_w, busy_w}), 32'({3'b111, 3'b000}));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    repeat (95000) @(posedge clk);
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
